// File: rtl/irrigation_pkg.sv
// irrigation_pkg: shared FSM state type and sensor-to-request decision for the irrigation controllers.
package irrigation_pkg;
  typedef enum logic [1:0] {IDLE, RUN, COOL} seq_state_t;
  function automatic logic water_req(input logic earth, input logic air, input logic low_temp, input logic mid);
    return ~earth & (~air | (~low_temp & mid));
  endfunction
endpackage

// File: rtl/zone_request_filter.sv
// zone_request_filter: qualifies a request only after it has held for FILTER_TICKS consecutive ticks.
module zone_request_filter #(
  parameter int TICK_W = 8,
  parameter int FILTER_TICKS = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic req,
  output logic qualified
);
  localparam logic [TICK_W-1:0] LIM = TICK_W'(FILTER_TICKS);
  logic [TICK_W-1:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (!req) cnt <= '0;
    else if (tick && cnt != LIM) cnt <= cnt + 1'b1;
  // Gate with req so a dropped request disqualifies in the same cycle, before the clear lands.
  assign qualified = req && cnt == LIM;
endmodule

// File: rtl/irrigation_zone_sequencer.sv
// irrigation_zone_sequencer: round-robin single-valve sequencer with run timeout and cool-down per run.
module irrigation_zone_sequencer
  import irrigation_pkg::*;
#(
  parameter int ZONES = 4,
  parameter int TICK_W = 8,
  parameter int RUN_TICKS = 60,
  parameter int COOL_TICKS = 5,
  parameter int FILTER_TICKS = 3,
  parameter int ZW = $clog2(ZONES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [ZONES-1:0] earth_humidity,
  input  logic             air_humidity,
  input  logic             low_temperature,
  input  logic             mid_water_level,
  input  logic             inhibit,
  output logic [ZONES-1:0] splinker_bomb,
  output logic [ZW-1:0]    active_zone,
  output logic             busy,
  output logic             zone_done,
  output logic             aborted
);
  localparam logic [TICK_W-1:0] RUN_END = TICK_W'(RUN_TICKS - 1);
  localparam logic [TICK_W-1:0] COOL_END = TICK_W'(COOL_TICKS - 1);
  seq_state_t state, nstate;
  logic [ZONES-1:0] q;
  logic [TICK_W-1:0] cnt;
  logic [ZW-1:0] last, pick, idx;
  logic found, start, fin, abort;
  genvar g;
  generate
    for (g = 0; g < ZONES; g++) begin : g_filt
      zone_request_filter #(.TICK_W(TICK_W), .FILTER_TICKS(FILTER_TICKS)) u_filt (
        .clk(clk),
        .reset(reset),
        .tick(tick),
        .req(water_req(earth_humidity[g], air_humidity, low_temperature, mid_water_level)),
        .qualified(q[g])
      );
    end
  endgenerate
  // Search starts just after the last served zone, so a persistent requester cannot starve others.
  always_comb begin
    pick = last;
    found = 1'b0;
    idx = '0;
    for (int i = 1; i <= ZONES; i++) begin
      idx = ZW'((int'(last) + i) % ZONES);
      if (!found && q[idx]) begin
        found = 1'b1;
        pick = idx;
      end
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      active_zone <= '0;
      last <= ZW'(ZONES - 1);
      zone_done <= 1'b0;
      aborted <= 1'b0;
    end else begin
      state <= nstate;
      zone_done <= fin;
      aborted <= abort;
      cnt <= (nstate != state || state == IDLE) ? '0 : cnt + TICK_W'(tick);
      if (start) begin
        active_zone <= pick;
        last <= pick;
      end
    end
  always_comb begin
    nstate = state;
    start = 1'b0;
    fin = 1'b0;
    abort = 1'b0;
    if (state == IDLE) begin
      if (!inhibit && found) begin
        nstate = RUN;
        start = 1'b1;
      end
    end else if (state == RUN) begin
      if (inhibit) begin
        nstate = COOL;
        abort = 1'b1;
      end else if (!q[active_zone] || (tick && cnt == RUN_END)) begin
        nstate = COOL;
        fin = 1'b1;
      end
    end else if (tick && cnt == COOL_END) begin
      nstate = IDLE;
    end
  end
  always_comb begin
    splinker_bomb = (state == RUN) ? ZONES'(1) << active_zone : '0;
    busy = state != IDLE;
  end
endmodule

// File: tb/tb_irrigation_zone_sequencer.sv
// tb_irrigation_zone_sequencer: directed scenario tests for the zone sequencer with hand-computed expectations.
module tb_irrigation_zone_sequencer;
  logic clk = 1'b0;
  logic reset, tick, air, low, mid, inhibit;
  logic [3:0] earth;
  logic [3:0] bomb;
  logic [1:0] az;
  logic busy, done, ab;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  irrigation_zone_sequencer #(
    .ZONES(4), .TICK_W(8), .RUN_TICKS(60), .COOL_TICKS(5), .FILTER_TICKS(3), .ZW(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tick(tick),
    .earth_humidity(earth),
    .air_humidity(air),
    .low_temperature(low),
    .mid_water_level(mid),
    .inhibit(inhibit),
    .splinker_bomb(bomb),
    .active_zone(az),
    .busy(busy),
    .zone_done(done),
    .aborted(ab)
  );

  always @(negedge clk) begin
    total++;
    if ($countones(bomb) > 1) begin
      bad++;
      $display("FAIL onehot bomb=%b want at most one bit", bomb);
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic tk;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
  endtask

  task automatic tks(input int n);
    repeat (n) tk();
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick = 1'b0;
    earth = 4'hF;
    air = 1'b0;
    low = 1'b0;
    mid = 1'b0;
    inhibit = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_reset;
    do_reset();
    total++; if (bomb !== 4'b0000) begin bad++; $display("FAIL rst_bomb got=%b want=0000", bomb); end
    total++; if (az !== 2'd0) begin bad++; $display("FAIL rst_zone got=%0d want=0", az); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done); end
    total++; if (ab !== 1'b0) begin bad++; $display("FAIL rst_abort got=%b want=0", ab); end
  endtask

  task automatic test_first_run_and_round_robin;
    do_reset();
    earth = 4'b0101;
    tick = 1'b1;
    cyc();
    cyc();
    cyc();
    tick = 1'b0;
    total++; if (bomb !== 4'b0000) begin bad++; $display("FAIL qual_latency got=%b want=0000", bomb); end
    cyc();
    total++; if (bomb !== 4'b0010) begin bad++; $display("FAIL z1_open got=%b want=0010", bomb); end
    total++; if (az !== 2'd1) begin bad++; $display("FAIL z1_zone got=%0d want=1", az); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL z1_busy got=%b want=1", busy); end
    tks(59);
    total++; if (bomb !== 4'b0010) begin bad++; $display("FAIL z1_tick59 got=%b want=0010", bomb); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL z1_early_done got=%b want=0", done); end
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    total++; if (bomb !== 4'b0000) begin bad++; $display("FAIL z1_timeout got=%b want=0000", bomb); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL z1_done got=%b want=1", done); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL z1_cool_busy got=%b want=1", busy); end
    cyc();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL z1_done_pulse got=%b want=0", done); end
    tks(4);
    total++; if (bomb !== 4'b0000 || busy !== 1'b1) begin bad++; $display("FAIL z1_cool4 bomb=%b busy=%b want 0000/1", bomb, busy); end
    tk();
    total++; if (bomb !== 4'b1000) begin bad++; $display("FAIL z3_open got=%b want=1000", bomb); end
    total++; if (az !== 2'd3) begin bad++; $display("FAIL z3_zone got=%0d want=3", az); end
    tks(59);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL z3_done got=%b want=1", done); end
    tks(5);
    total++; if (bomb !== 4'b0010 || az !== 2'd1) begin bad++; $display("FAIL rr_back_z1 bomb=%b zone=%0d want 0010/1", bomb, az); end
  endtask

  task automatic test_soil_wet;
    do_reset();
    earth = 4'b1011;
    tks(2);
    total++; if (bomb !== 4'b0000) begin bad++; $display("FAIL z2_preq got=%b want=0000", bomb); end
    tk();
    total++; if (bomb !== 4'b0100 || az !== 2'd2) begin bad++; $display("FAIL z2_open bomb=%b zone=%0d want 0100/2", bomb, az); end
    tks(10);
    earth = 4'b1111;
    cyc();
    total++; if (bomb !== 4'b0000) begin bad++; $display("FAIL wet_close got=%b want=0000", bomb); end
    total++; if (done !== 1'b1 || ab !== 1'b0) begin bad++; $display("FAIL wet_done done=%b abort=%b want 1/0", done, ab); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL wet_busy got=%b want=1", busy); end
    cyc();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL wet_pulse got=%b want=0", done); end
    tks(4);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL wet_cool4 got=%b want=1", busy); end
    tk();
    total++; if (busy !== 1'b0 || bomb !== 4'b0000) begin bad++; $display("FAIL wet_idle busy=%b bomb=%b want 0/0000", busy, bomb); end
  endtask

  task automatic test_inhibit;
    do_reset();
    earth = 4'b1110;
    tks(3);
    total++; if (bomb !== 4'b0001) begin bad++; $display("FAIL z0_open got=%b want=0001", bomb); end
    tks(19);
    tick = 1'b1;
    inhibit = 1'b1;
    cyc();
    tick = 1'b0;
    total++; if (bomb !== 4'b0000) begin bad++; $display("FAIL inh_close got=%b want=0000", bomb); end
    total++; if (ab !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL inh_abort abort=%b done=%b want 1/0", ab, done); end
    cyc();
    total++; if (ab !== 1'b0) begin bad++; $display("FAIL inh_pulse got=%b want=0", ab); end
    tks(5);
    total++; if (busy !== 1'b0 || bomb !== 4'b0000) begin bad++; $display("FAIL inh_block busy=%b bomb=%b want 0/0000", busy, bomb); end
    tks(3);
    total++; if (busy !== 1'b0 || bomb !== 4'b0000) begin bad++; $display("FAIL inh_hold busy=%b bomb=%b want 0/0000", busy, bomb); end
    inhibit = 1'b0;
    cyc();
    total++; if (bomb !== 4'b0001) begin bad++; $display("FAIL inh_release got=%b want=0001", bomb); end
    earth = 4'b1111;
    inhibit = 1'b1;
    cyc();
    total++; if (ab !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL inh_priority abort=%b done=%b want 1/0", ab, done); end
    inhibit = 1'b0;
  endtask

  task automatic test_mid_toggle;
    do_reset();
    air = 1'b1;
    earth = 4'b1110;
    for (int i = 0; i < 8; i++) begin
      mid = ~mid;
      tk();
      total++; if (bomb !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL toggle_%0d bomb=%b busy=%b want 0000/0", i, bomb, busy); end
    end
    low = 1'b1;
    mid = 1'b1;
    tks(4);
    total++; if (bomb !== 4'b0000) begin bad++; $display("FAIL cold_humid got=%b want=0000", bomb); end
    low = 1'b0;
    tks(3);
    total++; if (bomb !== 4'b0001) begin bad++; $display("FAIL mid_path got=%b want=0001", bomb); end
  endtask

  task automatic test_async_reset;
    do_reset();
    earth = 4'b1101;
    tks(3);
    total++; if (bomb !== 4'b0010) begin bad++; $display("FAIL ar_open got=%b want=0010", bomb); end
    tks(2);
    #2 reset = 1'b1;
    #1;
    total++; if (bomb !== 4'b0000) begin bad++; $display("FAIL ar_close got=%b want=0000", bomb); end
    total++; if (busy !== 1'b0 || az !== 2'd0) begin bad++; $display("FAIL ar_state busy=%b zone=%0d want 0/0", busy, az); end
    #1 reset = 1'b0;
    earth = 4'b1010;
    cyc();
    tks(3);
    total++; if (bomb !== 4'b0001 || az !== 2'd0) begin bad++; $display("FAIL ar_last bomb=%b zone=%0d want 0001/0", bomb, az); end
  endtask

  initial begin
    test_reset();
    test_first_run_and_round_robin();
    test_soil_wet();
    test_inhibit();
    test_mid_toggle();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/irrigation_zone_sequencer.md
Name: irrigation_zone_sequencer

Overview:
- Multi-zone sprinkler controller: generalises the single-valve sprinkler decision to ZONES independent soil sensors sharing one pump/water line.
- Evaluates per-zone watering requests, filters them against sensor chatter, and opens at most one zone valve at a time in round-robin order.
- Each run is bounded by a tick-based run timer, and every run is followed by a cool-down.
- Sits between the sensor inputs and the valve drivers; the Irrigation Controller supplies `inhibit` for critical water level or sensor fault.

Parameters:
- ZONES, 4, number of zones/valves (>=2).
- TICK_W, 8, width of run, cool-down and filter counters.
- RUN_TICKS, 60, maximum open time per run in `tick` strobes (1..2^TICK_W-1).
- COOL_TICKS, 5, all-closed gap after every run in ticks (>=1).
- FILTER_TICKS, 3, consecutive ticks a zone request must hold before it qualifies (>=1).
- ZW, $clog2(ZONES), zone index width (derived).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- tick  in  1  one-cycle timebase strobe; all timers advance only on tick.
- earth_humidity  in  ZONES  per-zone soil wet flag (1 = wet).
- air_humidity  in  1  1 = humid air.
- low_temperature  in  1  1 = low temperature.
- mid_water_level  in  1  1 = supply at middle level or above.
- inhibit  in  1  1 = water critical or supply sensor fault; forces all valves closed.
- splinker_bomb  out  ZONES  one-hot-or-zero valve drive, registered.
- active_zone  out  ZW  index of open (or last opened) zone.
- busy  out  1  1 in RUN or COOL.
- zone_done  out  1  one-cycle pulse when a run ends normally (timeout or soil wet).
- aborted  out  1  one-cycle pulse when a run ends due to inhibit.

Behaviour:
- Raw request per zone i: req_i = ~earth_humidity[i] & (~air_humidity | (~low_temperature & mid_water_level)).
- Request filter, per zone: the counter increments on tick while req_i=1 and clears on any cycle with req_i=0. The zone qualifies (q_i=1) when the counter reaches FILTER_TICKS and stays qualified while req_i=1. The counter saturates and does not wrap.
- Reset values: state=IDLE, all outputs 0, active_zone=0, round-robin pointer last=ZONES-1, all counters 0.
- FSM states:
  - IDLE:
    - splinker_bomb=0.
    - If inhibit=0 and any q_i=1: select the first qualified zone searching last+1, last+2, … modulo ZONES.
    - Load active_zone and last, clear run counter, go to RUN. The valve bit asserts in the cycle after selection (one-cycle latency from q_i to valve).
  - RUN:
    - splinker_bomb = one-hot(active_zone).
    - Run counter increments on tick.
    - Exit to COOL with zone_done=1 when q_active drops (soil wet), or on the tick at which the counter reaches RUN_TICKS-1.
    - If inhibit=1: exit to COOL with aborted=1 instead. Inhibit has priority over both zone_done conditions in the same cycle.
    - Valve is 0 from the cycle after the exit decision.
  - COOL:
    - splinker_bomb=0.
    - Counter counts COOL_TICKS ticks, then go to IDLE.
    - inhibit does not shorten or extend COOL.
- Simultaneous events: a new request arriving in COOL is held by the filter and not served until IDLE. Inhibit held in IDLE blocks every start, and filter counters keep running.
- Round-robin: last updates only on selection, so a zone that keeps requesting cannot starve others.
- Asynchronous reset mid-RUN: valves close immediately (reset is asynchronous) and state goes to IDLE.
- Invariant: popcount(splinker_bomb) <= 1 in every cycle.

Decomposition:
- Shared package `irrigation_pkg`:
  - State enum `seq_state_t` {IDLE, RUN, COOL}.
  - Function computing req_i from the four sensor bits, reused by the single-zone controller.
- Sub-module `zone_request_filter` (one instance per zone, via generate): inputs clk, reset, tick, req; output qualified; parameters TICK_W and FILTER_TICKS.
- Arbiter and FSM stay in the top module.

Test Plan:
- Reset, then zones 1 and 3 dry with air_humidity=0 held for 3 ticks → zone 1 valve (splinker_bomb=4'b0010) one cycle after qualification.
- Zone 1 runs 60 ticks → zone_done pulse, 5 idle ticks, then splinker_bomb=4'b1000 for zone 3.
- Zone 2 running, earth_humidity[2] rises at tick 10 → valve closes next cycle, zone_done=1, busy stays 1 through 5 COOL ticks.
- inhibit=1 at tick 20 of a run → aborted=1, valve 0 next cycle; with inhibit still high after COOL, no new run starts.
- air_humidity=1, low_temperature=0, mid_water_level toggling every tick on a dry zone → filter never qualifies, valves stay 0.
- Reset asserted asynchronously mid-RUN → splinker_bomb=0 without waiting for a clk edge; after release the FSM restarts in IDLE with last=ZONES-1.
